// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundles the instruction-fetch unit's bus signals: the instruction-memory
// read port, the redirect/halt control inputs from the core, and the IF/ID
// valid/ready output toward decode.
//
//   read_addr      fetch -> mem     word address, pc[ADDR_WIDTH+1:2]
//   read_data      mem   -> fetch   combinational instruction word
//   redirect_valid core  -> fetch   taken branch/jump this cycle
//   redirect_pc    core  -> fetch   redirect target byte address
//   halt_req       core  -> fetch   stop fetching
//   out_valid      fetch -> decode  IF/ID register holds an instruction
//   out_ready      decode-> fetch   decode accepts this cycle
//   out_instr      fetch -> decode  fetched instruction
//   out_pc         fetch -> decode  byte address of out_instr
//   out_pc_plus4   fetch -> decode  out_pc + 4 (mod 2^32)
//   fetch_fault    fetch -> core    misaligned redirect (only with
//                                   INST_FETCH_ALIGN_CHECK_EN defined)
//
// Modports: master = fetch unit side, slave = memory/core/decode side.
// ---------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  halt_req;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [31:0]           out_pc;
    logic [31:0]           out_pc_plus4;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic                  fetch_fault;
`endif

    modport master (
        output read_addr,
        input  read_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
`ifdef INST_FETCH_ALIGN_CHECK_EN
        ,
        output fetch_fault
`endif
    );

    modport slave (
        input  read_addr,
        output read_data,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
`ifdef INST_FETCH_ALIGN_CHECK_EN
        ,
        input  fetch_fault
`endif
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit for the MIPS core. Holds the program counter, drives
// the word address to the instruction memory, and captures the combinational
// read data into an IF/ID register with a valid/ready handshake to decode.
// Supports branch/jump redirect (one-bubble flush), decode back-pressure and
// a halt request.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high; overrides every other input
//   bus    - inst_fetch_if.master (memory port, redirect/halt, IF/ID output)
//
// Optional feature: define INST_FETCH_ALIGN_CHECK_EN to flag redirects whose
// target has non-zero low bits. The unit then raises fetch_fault and parks in
// FAULT until reset. Without the macro the low bits are silently cleared.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
`ifdef INST_FETCH_ALIGN_CHECK_EN
        ,
        ST_FAULT  = 2'd3
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [31:0]           out_pc_q, out_pc_d;
    logic [31:0]           out_pc_plus4_q, out_pc_plus4_d;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic                  fault_q, fault_d;
    logic                  fault_set;
`endif

    // Control strobes decoded from state and inputs
    logic adv;            // IF/ID register is free or being drained this cycle
    logic redirect_take;  // redirect honoured in the current state
    logic capture;        // load read_data into the IF/ID register
    logic handshake;      // decode consumes the held instruction

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic; redirect outranks halt in every live state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (bus.halt_req) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            ST_FAULT:  state_d = ST_FAULT;
`endif
            default:   state_d = ST_BOOT;
        endcase
        if (redirect_take) begin
            state_d = ST_RUN;
        end
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (fault_set) begin
            state_d = ST_FAULT;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // FSM output logic: strobes that steer the datapath
    // -----------------------------------------------------------------------
    always_comb begin
        adv           = !out_valid_q || bus.out_ready;
        handshake     = out_valid_q && bus.out_ready;
        redirect_take = bus.redirect_valid;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (state_q == ST_FAULT) begin
            redirect_take = 1'b0;
        end
        fault_set = redirect_take && (bus.redirect_pc[1:0] != 2'b00);
`endif
        // A redirect flushes the fetch slot on the same edge, so nothing is
        // captured then even if the register could advance.
        capture = (state_q == ST_RUN) && !bus.redirect_valid && adv;
    end

    // -----------------------------------------------------------------------
    // Datapath next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        fault_d        = fault_q | fault_set;
`endif

        if (redirect_take) begin
            // Target is word-aligned by dropping the byte offset.
            pc_d        = bus.redirect_pc & ~32'h0000_0003;
            out_valid_d = 1'b0;
        end else if (capture) begin
            pc_d           = pc_q + 32'd4;
            out_valid_d    = 1'b1;
            out_instr_d    = bus.read_data;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_q + 32'd4;
        end else if (handshake) begin
            // Drained with no replacement (halted, booting or faulted).
            out_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= 32'd0;
            out_pc_plus4_q <= 32'd0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            fault_q        <= 1'b0;
`endif
        end else begin
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            fault_q        <= fault_d;
`endif
        end
    end

    // read_addr depends on the pc register only, never on an input.
    assign bus.read_addr    = pc_q[ADDR_WIDTH+1:2];
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_pc_plus4 = out_pc_plus4_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault  = fault_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;

    logic clk;
    logic reset;
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    int n_pass;
    int n_total;

    inst_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    inst_fetch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Combinational instruction memory
    assign bus.read_data = mem[bus.read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_instr !== 32'h0) $display("FAIL rst_instr: got %h want 00000000", bus.out_instr); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_pc_plus4 !== 32'h0) $display("FAIL rst_pc4: got %h want 00000000", bus.out_pc_plus4); else n_pass++;
        n_total++; if (bus.read_addr !== 10'h0) $display("FAIL rst_raddr: got %h want 000", bus.read_addr); else n_pass++;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        n_total++; if (bus.fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", bus.fetch_fault); else n_pass++;
`endif
        reset = 1'b0;
        step();  // E1: BOOT -> RUN, nothing fetched yet
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33; exp_instr[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); else n_pass++;
            n_total++; if (bus.out_instr !== exp_instr[i]) $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.out_instr, exp_instr[i]); else n_pass++;
            n_total++; if (bus.out_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.out_pc, 32'(4 * i)); else n_pass++;
            n_total++; if (bus.out_pc_plus4 !== 32'(4 * i + 4)) $display("FAIL stream_pc4[%0d]: got %h want %h", i, bus.out_pc_plus4, 32'(4 * i + 4)); else n_pass++;
        end
        n_total++; if (bus.read_addr !== 10'd4) $display("FAIL stream_raddr: got %h want 004", bus.read_addr); else n_pass++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); else n_pass++;
            n_total++; if (bus.out_instr !== 32'h44) $display("FAIL bp_instr[%0d]: got %h want 00000044", i, bus.out_instr); else n_pass++;
            n_total++; if (bus.out_pc !== 32'hC) $display("FAIL bp_pc[%0d]: got %h want 0000000c", i, bus.out_pc); else n_pass++;
            n_total++; if (bus.read_addr !== 10'd4) $display("FAIL bp_raddr[%0d]: got %h want 004", i, bus.read_addr); else n_pass++;
        end
        bus.out_ready = 1'b1;
        step();
        n_total++; if (bus.out_pc !== 32'h10) $display("FAIL bp_resume_pc: got %h want 00000010", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'hA000_0004) $display("FAIL bp_resume_instr: got %h want a0000004", bus.out_instr); else n_pass++;
        step();
        n_total++; if (bus.out_pc !== 32'h14) $display("FAIL bp_next_pc: got %h want 00000014", bus.out_pc); else n_pass++;
    endtask

    task automatic test_redirect();
        // Steer to 0x8 so that instruction is presented and then consumed
        // on the same edge as the redirect to 0x40.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL redir8_bubble: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd2) $display("FAIL redir8_raddr: got %h want 002", bus.read_addr); else n_pass++;
        step();
        n_total++; if (bus.out_pc !== 32'h8) $display("FAIL redir8_pc: got %h want 00000008", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'h33) $display("FAIL redir8_instr: got %h want 00000033", bus.out_instr); else n_pass++;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL redir40_bubble: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd16) $display("FAIL redir40_raddr: got %h want 010", bus.read_addr); else n_pass++;
        step();
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL redir40_valid: got %b want 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h40) $display("FAIL redir40_pc: got %h want 00000040", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'hA000_0010) $display("FAIL redir40_instr: got %h want a0000010", bus.out_instr); else n_pass++;
        n_total++; if (bus.out_pc_plus4 !== 32'h44) $display("FAIL redir40_pc4: got %h want 00000044", bus.out_pc_plus4); else n_pass++;
    endtask

    task automatic test_halt();
        bus.halt_req = 1'b1;
        step();  // last capture (0x44) on the halting edge
        bus.halt_req = 1'b0;
        n_total++; if (bus.out_pc !== 32'h44) $display("FAIL halt_last_pc: got %h want 00000044", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL halt_last_valid: got %b want 1", bus.out_valid); else n_pass++;
        step();  // drained, no replacement
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL halt_drain_valid: got %b want 0", bus.out_valid); else n_pass++;
        step();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL halt_idle_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd18) $display("FAIL halt_raddr: got %h want 012", bus.read_addr); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h44) $display("FAIL halt_hold_pc: got %h want 00000044", bus.out_pc); else n_pass++;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL halt_redir_bubble: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd64) $display("FAIL halt_redir_raddr: got %h want 040", bus.read_addr); else n_pass++;
        step();
        n_total++; if (bus.out_pc !== 32'h100) $display("FAIL halt_exit_pc: got %h want 00000100", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'hA000_0040) $display("FAIL halt_exit_instr: got %h want a0000040", bus.out_instr); else n_pass++;
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.read_addr !== 10'h3FF) $display("FAIL wrap_raddr_hi: got %h want 3ff", bus.read_addr); else n_pass++;
        step();
        n_total++; if (bus.out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", bus.out_pc_plus4); else n_pass++;
        n_total++; if (bus.out_instr !== 32'hA000_03FF) $display("FAIL wrap_instr: got %h want a00003ff", bus.out_instr); else n_pass++;
        n_total++; if (bus.read_addr !== 10'h000) $display("FAIL wrap_raddr_lo: got %h want 000", bus.read_addr); else n_pass++;
        step();
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL wrap_next_pc: got %h want 00000000", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'h11) $display("FAIL wrap_next_instr: got %h want 00000011", bus.out_instr); else n_pass++;
    endtask

    task automatic test_misaligned();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_bubble: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd16) $display("FAIL mis_raddr: got %h want 010", bus.read_addr); else n_pass++;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        n_total++; if (bus.fetch_fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", bus.fetch_fault); else n_pass++;
        step();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_fault_valid: got %b want 0", bus.out_valid); else n_pass++;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        step();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_ignore_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'd16) $display("FAIL mis_ignore_raddr: got %h want 010", bus.read_addr); else n_pass++;
        n_total++; if (bus.fetch_fault !== 1'b1) $display("FAIL mis_fault_sticky: got %b want 1", bus.fetch_fault); else n_pass++;
`else
        step();
        n_total++; if (bus.out_pc !== 32'h40) $display("FAIL mis_pc: got %h want 00000040", bus.out_pc); else n_pass++;
        n_total++; if (bus.out_instr !== 32'hA000_0010) $display("FAIL mis_instr: got %h want a0000010", bus.out_instr); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst2_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.read_addr !== 10'h0) $display("FAIL rst2_raddr: got %h want 000", bus.read_addr); else n_pass++;
        n_total++; if (bus.out_pc !== 32'h0) $display("FAIL rst2_pc: got %h want 00000000", bus.out_pc); else n_pass++;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        n_total++; if (bus.fetch_fault !== 1'b0) $display("FAIL rst2_fault: got %b want 0", bus.fetch_fault); else n_pass++;
`endif
        reset = 1'b0;
        step();
        step();
        n_total++; if (bus.out_instr !== 32'h11) $display("FAIL rst2_first_instr: got %h want 00000011", bus.out_instr); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
        end
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt_req       = 1'b0;
        bus.out_ready      = 1'b1;
        #1;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_misaligned();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
